xpb_lut_gen: RTL and testbench

//  Runtime-generated reduction-constant table for the modular-squaring pipeline.

---
 rtl/xpb_lut_gen.sv | 153 +++++++++++++++
 tb/tb_xpb_lut_gen.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xpb_lut_gen.sv
// ---------------------------------------------------------------------------
// xpb_lut_gen
//   Runtime-generated reduction-constant table for the modular-squaring
//   pipeline. A configuration request (C, M) is checked and then tabulated as
//   entry[j] = (j * C) mod M for j = 0..DEPTH-1. One entry is produced per
//   clock by repeated modular addition, so no multiplier is needed. Once the
//   fill is complete, the block serves registered lookups with 1-cycle latency.
//
// Ports
//   clk          clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   cfg_valid    configuration request
//   cfg_ready    configuration can be accepted (IDLE or READY)
//   cfg_base     constant C to tabulate
//   cfg_mod      modulus M
//   cfg_err      1-cycle pulse: rejected configuration (C >= M or M == 0)
//   busy         table fill in progress
//   table_ready  table valid, lookups served
//   rd_en        lookup request
//   rd_sel       entry index
//   rd_valid     rd_data valid this cycle
//   rd_data      entry[rd_sel], registered
// ---------------------------------------------------------------------------
module xpb_lut_gen #(
  parameter  int DATA_W = 1024,
  parameter  int SEL_W  = 5,
  localparam int DEPTH  = 2**SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DATA_W-1:0] cfg_base,
  input  logic [DATA_W-1:0] cfg_mod,
  output logic              cfg_err,
  output logic              busy,
  output logic              table_ready,
  input  logic              rd_en,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] mod_q, mod_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic              cfg_err_q, cfg_err_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W:0]   sum;
  logic              wr_en;

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign cfg_ready   = (state_q != S_FILL);
  assign busy        = (state_q == S_FILL);
  assign table_ready = (state_q == S_READY);
  assign cfg_err     = cfg_err_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;

  // Control path. The sum keeps its carry bit so that acc + C never wraps
  // before the comparison against M. Because acc < M and C < M, a single
  // conditional subtraction restores acc < M, and the subtraction result
  // always fits in DATA_W bits, so it is taken on the low bits only.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    mod_d     = mod_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    cfg_err_d = 1'b0;
    wr_en     = 1'b0;
    sum       = {1'b0, acc_q} + {1'b0, base_q};
    case (state_q)
      S_FILL: begin
        wr_en = 1'b1;
        if (sum >= {1'b0, mod_q}) begin
          acc_d = sum[DATA_W-1:0] - mod_q;
        end else begin
          acc_d = sum[DATA_W-1:0];
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == {SEL_W{1'b1}}) begin
          state_d = S_READY;
        end
      end
      default: begin
        // IDLE and READY both accept a new configuration; a bad one drops
        // any existing table back to IDLE.
        if (cfg_valid) begin
          if ((cfg_base >= cfg_mod) || (cfg_mod == '0)) begin
            cfg_err_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            base_d  = cfg_base;
            mod_d   = cfg_mod;
            acc_d   = '0;
            idx_d   = '0;
            state_d = S_FILL;
          end
        end
      end
    endcase
  end

  // Lookup path. A lookup in the same cycle as a reconfiguration still reads
  // the old table, since the first fill write only happens one edge later.
  always_comb begin
    rd_valid_d = rd_en && (state_q == S_READY);
    rd_data_d  = rd_data_q;
    if (rd_valid_d) begin
      rd_data_d = mem_q[rd_sel];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      mod_q      <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      cfg_err_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      mod_q      <= mod_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      cfg_err_q  <= cfg_err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Table storage has no reset; its contents are only trusted once a fill
  // has completed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx_q] <= acc_q;
    end
  end

endmodule

// File: tb/tb_xpb_lut_gen.sv
// ---------------------------------------------------------------------------
// tb_xpb_lut_gen
//   Self-checking bench for xpb_lut_gen. A small instance (16-bit data,
//   8 entries) exercises timing, error handling, lookups and reset; a full
//   size instance (1024-bit data, 32 entries) is filled with random C < M
//   pairs and compared against a multiply-and-modulo golden model.
// ---------------------------------------------------------------------------
module tb_xpb_lut_gen;

  localparam int SW = 16;
  localparam int SS = 3;
  localparam int SD = 8;
  localparam int BW = 1024;
  localparam int BS = 5;
  localparam int BD = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic          s_cfg_valid = 1'b0;
  logic          s_cfg_ready;
  logic [SW-1:0] s_cfg_base = '0;
  logic [SW-1:0] s_cfg_mod = '0;
  logic          s_cfg_err;
  logic          s_busy;
  logic          s_table_ready;
  logic          s_rd_en = 1'b0;
  logic [SS-1:0] s_rd_sel = '0;
  logic          s_rd_valid;
  logic [SW-1:0] s_rd_data;

  logic          b_cfg_valid = 1'b0;
  logic          b_cfg_ready;
  logic [BW-1:0] b_cfg_base = '0;
  logic [BW-1:0] b_cfg_mod = '0;
  logic          b_cfg_err;
  logic          b_busy;
  logic          b_table_ready;
  logic          b_rd_en = 1'b0;
  logic [BS-1:0] b_rd_sel = '0;
  logic          b_rd_valid;
  logic [BW-1:0] b_rd_data;

  int nVectors = 0;
  int nMiscompares = 0;

  logic [SW-1:0] sQueue[$];
  logic [BW-1:0] bQueue[$];
  logic [SW-1:0] lastS = '0;

  xpb_lut_gen #(.DATA_W(SW), .SEL_W(SS)) dutSmall (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(s_cfg_valid), .cfg_ready(s_cfg_ready),
    .cfg_base(s_cfg_base), .cfg_mod(s_cfg_mod), .cfg_err(s_cfg_err),
    .busy(s_busy), .table_ready(s_table_ready),
    .rd_en(s_rd_en), .rd_sel(s_rd_sel),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data)
  );

  xpb_lut_gen #(.DATA_W(BW), .SEL_W(BS)) dutBig (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(b_cfg_valid), .cfg_ready(b_cfg_ready),
    .cfg_base(b_cfg_base), .cfg_mod(b_cfg_mod), .cfg_err(b_cfg_err),
    .busy(b_busy), .table_ready(b_table_ready),
    .rd_en(b_rd_en), .rd_sel(b_rd_sel),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] modelSmall(input int j, input int c, input int m);
    return SW'((j * c) % m);
  endfunction

  function automatic logic [BW-1:0] modelBig(input int j, input logic [BW-1:0] c,
                                             input logic [BW-1:0] m);
    logic [BW+7:0] jw;
    logic [BW+7:0] prod;
    logic [BW+7:0] rem;
    jw = '0;
    jw[7:0] = 8'(j);
    prod = jw * {8'd0, c};
    rem = prod % {8'd0, m};
    return rem[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] randWide();
    logic [BW-1:0] v;
    for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic cfgSmall(input logic [SW-1:0] c, input logic [SW-1:0] m);
    s_cfg_valid = 1'b1;
    s_cfg_base  = c;
    s_cfg_mod   = m;
    step();
    s_cfg_valid = 1'b0;
  endtask

  // Checks the exact fill latency: table_ready low for DEPTH-1 edges after
  // the accepting edge, high after the DEPTH-th.
  task automatic test_fill_timing(input string name);
    nVectors++;
    if (s_busy !== 1'b1 || s_cfg_ready !== 1'b0 || s_table_ready !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL %s_start: busy=%b cfg_ready=%b table_ready=%b required 1 0 0",
               name, s_busy, s_cfg_ready, s_table_ready);
    end
    for (int k = 1; k <= SD; k++) begin
      step();
      nVectors++;
      if (s_table_ready !== (k == SD)) begin
        nMiscompares++;
        $display("[TB] FAIL %s_ready_k%0d: table_ready=%b required %b",
                 name, k, s_table_ready, (k == SD));
      end
    end
    nVectors++;
    if (s_busy !== 1'b0 || s_cfg_ready !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL %s_done: busy=%b cfg_ready=%b required 0 1",
               name, s_busy, s_cfg_ready);
    end
  endtask

  // Back-to-back lookups of every entry through the scoreboard queue.
  task automatic test_back_to_back(input string name, input int c, input int m);
    logic [SW-1:0] exp;
    for (int j = 0; j < SD; j++) begin
      s_rd_en  = 1'b1;
      s_rd_sel = SS'(j);
      sQueue.push_back(modelSmall(j, c, m));
      step();
      nVectors++;
      if (s_rd_valid !== 1'b1 || sQueue.size() == 0) begin
        nMiscompares++;
        $display("[TB] FAIL %s_valid_%0d: rd_valid=%b required 1", name, j, s_rd_valid);
        sQueue.delete();
      end else begin
        exp = sQueue.pop_front();
        lastS = exp;
        if (s_rd_data !== exp) begin
          nMiscompares++;
          $display("[TB] FAIL %s_entry_%0d: rd_data=%h required %h", name, j, s_rd_data, exp);
        end
      end
    end
    s_rd_en = 1'b0;
    step();
    nVectors++;
    if (s_rd_valid !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL %s_idle: rd_valid=%b required 0", name, s_rd_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    nVectors++;
    if (s_cfg_ready !== 1'b1 || s_cfg_err !== 1'b0 || s_busy !== 1'b0 ||
        s_table_ready !== 1'b0 || s_rd_valid !== 1'b0 || s_rd_data !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_small: rdy=%b err=%b busy=%b tr=%b rv=%b rd=%h required 1 0 0 0 0 0",
               s_cfg_ready, s_cfg_err, s_busy, s_table_ready, s_rd_valid, s_rd_data);
    end
    nVectors++;
    if (b_cfg_ready !== 1'b1 || b_cfg_err !== 1'b0 || b_busy !== 1'b0 ||
        b_table_ready !== 1'b0 || b_rd_valid !== 1'b0 || b_rd_data !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_big: rdy=%b err=%b busy=%b tr=%b rv=%b required 1 0 0 0 0",
               b_cfg_ready, b_cfg_err, b_busy, b_table_ready, b_rd_valid);
    end
    rst_n = 1'b1;
    lastS = '0;
    step();
  endtask

  task automatic test_fill_basic();
    cfgSmall(16'd5, 16'd13);
    test_fill_timing("fill_5_13");
    test_back_to_back("table_5_13", 5, 13);
  endtask

  task automatic test_carry();
    cfgSmall(16'hFFFE, 16'hFFFF);
    test_fill_timing("fill_carry");
    test_back_to_back("table_carry", 32'hFFFE, 32'hFFFF);
  endtask

  // Reconfiguration from READY with a simultaneous lookup, then lookups and
  // an ignored configuration attempt during the fill.
  task automatic test_reconfig();
    logic [SW-1:0] oldEntry;
    oldEntry = modelSmall(4, 32'hFFFE, 32'hFFFF);
    s_cfg_valid = 1'b1;
    s_cfg_base  = 16'd2;
    s_cfg_mod   = 16'd11;
    s_rd_en     = 1'b1;
    s_rd_sel    = 3'd4;
    step();
    s_cfg_valid = 1'b0;
    s_rd_en     = 1'b0;
    nVectors++;
    if (s_rd_valid !== 1'b1 || s_rd_data !== oldEntry) begin
      nMiscompares++;
      $display("[TB] FAIL reconfig_old_read: rd_valid=%b rd_data=%h required 1 %h",
               s_rd_valid, s_rd_data, oldEntry);
    end
    lastS = oldEntry;
    nVectors++;
    if (s_table_ready !== 1'b0 || s_busy !== 1'b1) begin
      nMiscompares++;
      $display("[TB] FAIL reconfig_state: table_ready=%b busy=%b required 0 1",
               s_table_ready, s_busy);
    end
    s_rd_en     = 1'b1;
    s_rd_sel    = 3'd2;
    s_cfg_valid = 1'b1;
    s_cfg_base  = 16'd13;
    s_cfg_mod   = 16'd13;
    for (int k = 1; k < SD; k++) begin
      step();
      nVectors++;
      if (s_rd_valid !== 1'b0 || s_rd_data !== lastS || s_cfg_err !== 1'b0) begin
        nMiscompares++;
        $display("[TB] FAIL fill_rd_ignored_%0d: rd_valid=%b rd_data=%h cfg_err=%b required 0 %h 0",
                 k, s_rd_valid, s_rd_data, s_cfg_err, lastS);
      end
    end
    s_rd_en     = 1'b0;
    s_cfg_valid = 1'b0;
    step();
    nVectors++;
    if (s_table_ready !== 1'b1 || s_cfg_err !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL reconfig_ready: table_ready=%b cfg_err=%b required 1 0",
               s_table_ready, s_cfg_err);
    end
    test_back_to_back("table_2_11", 2, 11);
  endtask

  task automatic test_cfg_err();
    logic [SW-1:0] badC [2];
    logic [SW-1:0] badM [2];
    badC[0] = 16'd13; badM[0] = 16'd13;
    badC[1] = 16'd5;  badM[1] = 16'd0;
    for (int i = 0; i < 2; i++) begin
      cfgSmall(badC[i], badM[i]);
      nVectors++;
      if (s_cfg_err !== 1'b1 || s_table_ready !== 1'b0 || s_busy !== 1'b0 ||
          s_cfg_ready !== 1'b1) begin
        nMiscompares++;
        $display("[TB] FAIL cfg_err_pulse_%0d: err=%b tr=%b busy=%b rdy=%b required 1 0 0 1",
                 i, s_cfg_err, s_table_ready, s_busy, s_cfg_ready);
      end
      s_rd_en  = 1'b1;
      s_rd_sel = 3'd1;
      for (int k = 0; k < 3; k++) begin
        step();
        nVectors++;
        if (s_cfg_err !== 1'b0 || s_busy !== 1'b0 || s_rd_valid !== 1'b0 ||
            s_rd_data !== lastS) begin
          nMiscompares++;
          $display("[TB] FAIL cfg_err_after_%0d_%0d: err=%b busy=%b rv=%b rd=%h required 0 0 0 %h",
                   i, k, s_cfg_err, s_busy, s_rd_valid, s_rd_data, lastS);
        end
      end
      s_rd_en = 1'b0;
    end
  endtask

  task automatic test_reset_mid_fill();
    cfgSmall(16'd5, 16'd13);
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    nVectors++;
    if (s_busy !== 1'b0 || s_table_ready !== 1'b0 || s_cfg_ready !== 1'b1 ||
        s_rd_valid !== 1'b0 || s_rd_data !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_mid_fill: busy=%b tr=%b rdy=%b rv=%b rd=%h required 0 0 1 0 0",
               s_busy, s_table_ready, s_cfg_ready, s_rd_valid, s_rd_data);
    end
    lastS = '0;
    step();
    rst_n = 1'b1;
    step();
    nVectors++;
    if (s_busy !== 1'b0 || s_table_ready !== 1'b0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_release: busy=%b tr=%b required 0 0", s_busy, s_table_ready);
    end
    cfgSmall(16'd3, 16'd7);
    test_fill_timing("fill_3_7");
    test_back_to_back("table_3_7", 3, 7);
  endtask

  task automatic test_random_big();
    logic [BW-1:0] c;
    logic [BW-1:0] m;
    logic [BW-1:0] exp;
    int n;
    for (int p = 0; p < 50; p++) begin
      m = randWide() >> $urandom_range(0, BW - 2);
      if (m == '0) m = 1;
      c = randWide() % m;
      b_cfg_valid = 1'b1;
      b_cfg_base  = c;
      b_cfg_mod   = m;
      step();
      b_cfg_valid = 1'b0;
      n = 0;
      while (b_table_ready !== 1'b1 && n < BD + 8) begin
        step();
        n++;
      end
      nVectors++;
      if (n != BD || b_table_ready !== 1'b1) begin
        nMiscompares++;
        $display("[TB] FAIL big_fill_%0d: ready after %0d cycles (table_ready=%b) required %0d",
                 p, n, b_table_ready, BD);
      end
      for (int j = 0; j < BD; j++) begin
        b_rd_en  = 1'b1;
        b_rd_sel = BS'(j);
        bQueue.push_back(modelBig(j, c, m));
        step();
        nVectors++;
        if (b_rd_valid !== 1'b1 || bQueue.size() == 0) begin
          nMiscompares++;
          $display("[TB] FAIL big_valid_%0d_%0d: rd_valid=%b required 1", p, j, b_rd_valid);
          bQueue.delete();
        end else begin
          exp = bQueue.pop_front();
          if (b_rd_data !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL big_entry_%0d_%0d: rd_data low64=%h required low64=%h",
                     p, j, b_rd_data[63:0], exp[63:0]);
          end
        end
      end
      b_rd_en = 1'b0;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_fill_basic();
    test_carry();
    test_reconfig();
    test_cfg_err();
    test_reset_mid_fill();
    test_random_big();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
